// File: rtl/quad_step_gen.sv
// quad_step_gen -- quadrature rotary-encoder waveform generator.
//
// Emulates a detented rotary encoder: accepts "N detents, direction D"
// commands and plays out one full 4-phase gray-code A/B cycle per detent.
// Every A/B state, including the 00 rest level between detents, is held
// for PHASE_CYCLES clocks.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   cmd_valid  command offered
//   cmd_dir    1 = CW (A leads), 0 = CCW (B leads)
//   cmd_count  detents to generate (0 is legal: finishes with no A/B activity)
//   cmd_ready  generator idle; command accepted on a valid && ready edge
//   abort      stop after the current detent completes
//   ROT_A      quadrature channel A (registered)
//   ROT_B      quadrature channel B (registered)
//   busy       command in progress (= ~cmd_ready)
//   remaining  detents not yet completed
//   done       1-cycle pulse when a command finishes or aborts
//   aborted    qualifies done: command ended early by abort
module quad_step_gen #(
    parameter int PHASE_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             cmd_ready,
    input  logic             abort,
    output logic             ROT_A,
    output logic             ROT_B,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic             done,
    output logic             aborted
);

    localparam int TMR_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(PHASE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [1:0]       phase_reg;
    logic             dir_reg;
    logic             abort_pend_reg;
    logic             rot_a_reg;
    logic             rot_b_reg;
    logic             done_reg;
    logic             aborted_reg;
    logic [CNT_W-1:0] remaining_reg;

    logic [1:0]       phase_next;
    logic             lead_next;
    logic             lag_next;
    logic             abort_now;

    // Phase index 0..3 maps to the leading/lagging channel pattern
    // 00 -> 10 -> 11 -> 01. CW puts the leading bit on A, CCW on B.
    always_comb begin
        phase_next = phase_reg + 2'd1;
        lead_next  = phase_next[1] ^ phase_next[0];
        lag_next   = phase_next[1];
    end

    // An abort arriving on the very edge a detent completes still counts.
    assign abort_now = abort_pend_reg | abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            phase_reg      <= 2'd0;
            dir_reg        <= 1'b0;
            abort_pend_reg <= 1'b0;
            rot_a_reg      <= 1'b0;
            rot_b_reg      <= 1'b0;
            done_reg       <= 1'b0;
            aborted_reg    <= 1'b0;
            remaining_reg  <= '0;
        end else begin
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    abort_pend_reg <= 1'b0;
                    if (cmd_valid) begin
                        dir_reg <= cmd_dir;
                        if (cmd_count == '0) begin
                            state_reg <= FINISH;
                        end else begin
                            remaining_reg <= cmd_count;
                            timer_reg     <= TMR_RELOAD;
                            phase_reg     <= 2'd0;
                            state_reg     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        abort_pend_reg <= 1'b1;
                    end
                    if (timer_reg != '0) begin
                        timer_reg <= timer_reg - TMR_W'(1);
                    end else begin
                        timer_reg <= TMR_RELOAD;
                        phase_reg <= phase_next;
                        rot_a_reg <= dir_reg ? lead_next : lag_next;
                        rot_b_reg <= dir_reg ? lag_next : lead_next;
                        // Phase 3 -> 0 is the return to rest: a detent completed.
                        if (phase_reg == 2'd3) begin
                            remaining_reg <= remaining_reg - CNT_W'(1);
                            if (remaining_reg == CNT_W'(1) || abort_now) begin
                                state_reg <= FINISH;
                            end
                        end
                    end
                end
                FINISH: begin
                    done_reg    <= 1'b1;
                    aborted_reg <= abort_pend_reg;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = ~cmd_ready;
    assign ROT_A     = rot_a_reg;
    assign ROT_B     = rot_b_reg;
    assign remaining = remaining_reg;
    assign done      = done_reg;
    assign aborted   = aborted_reg;

endmodule
